data_mem_bridge: RTL and testbench
==================================

# data_mem_bridge

Sits directly downstream of the pipeline's memory stage and carries every 22-bit data-memory access out over an 8-bit request/acknowledge byte bus. Each access becomes three sequential byte transfers. While an access is in flight the bridge holds the pipeline with `cpu_stall`. It returns read data as one 22-bit word and flags bus timeouts with a sticky error bit.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum consecutive no-ack cycles allowed on one byte before the access is aborted. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  access valid this cycle (memory stage load or store).
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_adr`  in  22  word address.
- `cpu_wdata`  in  22  store data.
- `cpu_rdata`  out  22  load result; registered; holds until the next load completes.
- `cpu_stall`  out  1  freeze the pipeline; combinational from state and `cpu_req`.
- `bus_req`  out  1  byte transfer request; registered.
- `bus_we`  out  1  byte write enable; registered.
- `bus_adr`  out  24  byte address = {word address, byte index[1:0]}; registered.
- `bus_wdata`  out  8  write byte; registered.
- `bus_rdata`  in  8  read byte, sampled on ack.
- `bus_ack`  in  1  transfer complete; counted only when `bus_req` is high.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- Word-to-byte mapping is little-endian:
  - byte 0 = bits [7:0]
  - byte 1 = bits [15:8]
  - byte 2 = {2'b00, bits [21:16]}
  - On loads, bits [7:6] of byte 2 are discarded.
- FSM states and transitions:
  - **IDLE**: on `cpu_req`, latch `cpu_adr`, `cpu_we` and `cpu_wdata`; clear the byte index; go to REQ.
  - **REQ**: `bus_req` is high and `bus_adr`, `bus_we`, `bus_wdata` stay stable. When `bus_ack` is high at the edge:
    - capture the byte on a load;
    - go to GAP if the byte index < 2;
    - otherwise go to DONE.
  - **GAP**: `bus_req` is low for one cycle; increment the byte index; go to REQ.
  - **DONE**: `cpu_stall` is low for one cycle so the pipeline advances; go to IDLE.
- `cpu_stall` = (IDLE and `cpu_req`) or REQ or GAP. It is forced to 0 while `rst` is high.
- Timeout:
  - The wait counter clears on every entry to REQ and increments on each REQ cycle with no ack.
  - After `WAIT_MAX` such cycles the access aborts: set `bus_err`, skip the remaining bytes, load 22'h0 into `cpu_rdata` if the access was a load, and go to DONE.
  - If ack and timeout occur on the same edge, the ack wins.
- `bus_err` clears only on `rst`.
- Reset at any point, including mid-access:
  - state goes to IDLE;
  - all registered outputs clear;
  - latched and buffered accesses are discarded and no partial completion occurs.

## Timing
- Zero-wait bus (ack in the first REQ cycle) = 7 cycles per access: request seen in cycle 0; stall high in cycles 0–5; DONE in cycle 6.
- Each extra wait cycle per byte adds 1 stall cycle.
- Reset values: `cpu_rdata` 0, `bus_req` 0, `bus_we` 0, `bus_adr` 0, `bus_wdata` 0, `bus_err` 0, `cpu_stall` 0.
- `cpu_rdata` updates at the edge that enters DONE, so it is valid during the DONE cycle.

## Configuration
- `DATA_MEM_BRIDGE_POSTED_WRITE_EN` defined (one-entry posted write buffer):
  - A store accepted in IDLE raises no stall. The transfer runs in the background and returns to IDLE without a DONE cycle.
  - A `cpu_req` arriving while busy stalls until the background store finishes, then is serviced normally.
  - Loads are never posted.
- Macro undefined: stores stall exactly like loads.

## Structure
- Package `data_mem_bridge_pkg` holds:
  - the state enum typedef;
  - `WORD_W` = 22;
  - `BYTES_PER_WORD` = 3;
  - `BUS_ADR_W` = 24.
- One sub-module, `bridge_wait_timer`: the clear/increment/expire counter sized from `WAIT_MAX`.

## Test plan
- **Store, zero-wait**: store to `cpu_adr` 22'h000010 with data 22'h3ABCDE → bus writes DE @24'h000040, BC @24'h000041, 3A @24'h000042; `cpu_stall` high for exactly 6 cycles.
- **Load, zero-wait**: load from 22'h000005, bus returns 11, 22, FF → `cpu_rdata` = 22'h3F2211 in the DONE cycle (cycle 6).
- **Wait states**: ack delayed 3 cycles on every byte → stall high for 15 cycles; `bus_adr`/`bus_wdata` unchanged while `bus_req` is high; `bus_req` low during each GAP cycle.
- **Timeout**: `WAIT_MAX` = 15 and no ack on byte 0 of a load → abort after 15 REQ cycles; `bus_err` = 1, `cpu_rdata` = 0, stall drops; `bus_err` stays 1 through later accesses until `rst`.
- **Reset mid-access**: `rst` pulsed while byte 1 of a store is in REQ → next cycle `bus_req` = 0 and `cpu_stall` = 0; no byte 2 is issued; the next access starts at byte 0.
- **Posted writes (macro defined)**: store then immediately a load to the same address → store gives 0 stall cycles; load stall covers the store's remaining bytes plus 7; `cpu_rdata` equals the stored word.

Source files
------------

// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - shared types and widths for data_mem_bridge
package data_mem_bridge_pkg;

   localparam int WORD_W         = 22;
   localparam int BYTES_PER_WORD = 3;
   localparam int BUS_ADR_W      = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_DONE
   } state_e;

   // Little-endian lane select; the top lane carries only the six upper word bits.
   function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         default: b = {2'b00, w[21:16]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bridge_wait_timer.sv
// rtl/bridge_wait_timer.sv - per-byte no-ack counter that expires after WAIT_MAX idle REQ cycles
module bridge_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Fires on the no-ack cycle that would make the count reach WAIT_MAX.
   assign expire_o = inc_i && (cnt_q == CNT_W'(WAIT_MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - carries 22-bit data-memory accesses as three byte transfers on a req/ack bus
// Optional feature macro: DATA_MEM_BRIDGE_POSTED_WRITE_EN (one-entry posted store buffer).
module data_mem_bridge
   import data_mem_bridge_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [WORD_W-1:0]    cpu_adr_i,
   input  logic [WORD_W-1:0]    cpu_wdata_i,
   output logic [WORD_W-1:0]    cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 bus_req_o,
   output logic                 bus_we_o,
   output logic [BUS_ADR_W-1:0] bus_adr_o,
   output logic [7:0]           bus_wdata_o,
   input  logic [7:0]           bus_rdata_i,
   input  logic                 bus_ack_i,
   output logic                 bus_err_o
);

   state_e               state_q, state_d;
   logic [1:0]           idx_q, idx_d, idx_nxt;
   logic [WORD_W-1:0]    adr_q, adr_d, wdata_q, wdata_d;
   logic [WORD_W-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic                 we_q, we_d, posted_q, posted_d;
   logic [15:0]          rbuf_q, rbuf_d;
   logic                 bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic                 bus_err_q, bus_err_d;
   logic [BUS_ADR_W-1:0] bus_adr_q, bus_adr_d;
   logic [7:0]           bus_wdata_q, bus_wdata_d;
   logic                 tmr_clr, tmr_inc, tmr_expire;
   logic                 stall_c, finish;

   assign idx_nxt = idx_q + 2'd1;

   bridge_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmr_clr),
      .inc_i    (tmr_inc),
      .expire_o (tmr_expire)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      adr_d       = adr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      posted_d    = posted_q;
      rbuf_d      = rbuf_q;
      cpu_rdata_d = cpu_rdata_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_adr_d   = bus_adr_q;
      bus_wdata_d = bus_wdata_q;
      bus_err_d   = bus_err_q;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      stall_c     = 1'b0;
      finish      = 1'b0;

      case (state_q)
         ST_IDLE: begin
`ifdef DATA_MEM_BRIDGE_POSTED_WRITE_EN
            stall_c = cpu_req_i && !cpu_we_i;
`else
            stall_c = cpu_req_i;
`endif
            if (cpu_req_i) begin
               adr_d       = cpu_adr_i;
               we_d        = cpu_we_i;
               wdata_d     = cpu_wdata_i;
               idx_d       = 2'd0;
`ifdef DATA_MEM_BRIDGE_POSTED_WRITE_EN
               posted_d    = cpu_we_i;
`else
               posted_d    = 1'b0;
`endif
               bus_req_d   = 1'b1;
               bus_we_d    = cpu_we_i;
               bus_adr_d   = {cpu_adr_i, 2'd0};
               bus_wdata_d = word_byte(cpu_wdata_i, 2'd0);
               tmr_clr     = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // A posted store only holds the pipeline when a new access queues behind it.
            stall_c = posted_q ? cpu_req_i : 1'b1;
            tmr_inc = !bus_ack_i;
            if (bus_ack_i) begin
               if (!we_q) begin
                  case (idx_q)
                     2'd0:    rbuf_d[7:0]  = bus_rdata_i;
                     2'd1:    rbuf_d[15:8] = bus_rdata_i;
                     default: cpu_rdata_d  = WORD_W'({bus_rdata_i, rbuf_q});
                  endcase
               end
               if (idx_q < 2'(BYTES_PER_WORD - 1)) begin
                  bus_req_d = 1'b0;
                  state_d   = ST_GAP;
               end else begin
                  finish = 1'b1;
               end
            end else if (tmr_expire) begin
               bus_err_d = 1'b1;
               if (!we_q) begin
                  cpu_rdata_d = '0;
               end
               finish = 1'b1;
            end
         end
         ST_GAP: begin
            stall_c     = posted_q ? cpu_req_i : 1'b1;
            idx_d       = idx_nxt;
            bus_req_d   = 1'b1;
            bus_we_d    = we_q;
            bus_adr_d   = {adr_q, idx_nxt};
            bus_wdata_d = word_byte(wdata_q, idx_nxt);
            tmr_clr     = 1'b1;
            state_d     = ST_REQ;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (finish) begin
         bus_req_d = 1'b0;
         posted_d  = 1'b0;
         state_d   = posted_q ? ST_IDLE : ST_DONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         adr_q       <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         posted_q    <= 1'b0;
         rbuf_q      <= '0;
         cpu_rdata_q <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_adr_q   <= '0;
         bus_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         adr_q       <= adr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         posted_q    <= posted_d;
         rbuf_q      <= rbuf_d;
         cpu_rdata_q <= cpu_rdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_adr_q   <= bus_adr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign cpu_stall_o = stall_c && !rst_i;
   assign cpu_rdata_o = cpu_rdata_q;
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_adr_o   = bus_adr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge with a byte-bus memory and access model
module tb_data_mem_bridge;

   localparam int WAIT_MAX = 15;
   localparam int NEVER    = 1000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, cpu_we_i;
   logic [21:0] cpu_adr_i, cpu_wdata_i, cpu_rdata_o;
   logic        cpu_stall_o, bus_req_o, bus_we_o;
   logic [23:0] bus_adr_o;
   logic [7:0]  bus_wdata_o, bus_rdata_i;
   logic        bus_ack_i, bus_err_o;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [logic [23:0]];
   int          dly [4];
   int          bus_wait;
   logic [31:0] wr_q [$];
   logic [23:0] hold_adr;
   logic [7:0]  hold_wd;
   logic        hold_v;
   logic [21:0] rd_m;
   logic        err_m;

   data_mem_bridge #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_adr_i   (cpu_adr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_adr_o   (bus_adr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i),
      .bus_err_o   (bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] load_word(input logic [21:0] adr);
      logic [23:0] b;
      b = {adr, 2'b00};
      return 22'({mem[b + 24'd2], mem[b + 24'd1], mem[b]});
   endfunction

   // Bus slave: acks after dly[lane] wait cycles, checks request stability meanwhile.
   task automatic bus_step();
      if (bus_req_o) begin
         if (hold_v) begin
            chk("adr_stable", 32'(bus_adr_o), 32'(hold_adr));
            chk("wdata_stable", 32'(bus_wdata_o), 32'(hold_wd));
         end
         hold_v   = 1'b1;
         hold_adr = bus_adr_o;
         hold_wd  = bus_wdata_o;
         if (bus_wait >= dly[bus_adr_o[1:0]]) begin
            bus_ack_i = 1'b1;
            hold_v    = 1'b0;
            bus_wait  = 0;
            if (bus_we_o) begin
               mem[bus_adr_o] = bus_wdata_o;
               wr_q.push_back({bus_adr_o, bus_wdata_o});
            end else begin
               if (!mem.exists(bus_adr_o)) mem[bus_adr_o] = 8'($urandom);
               bus_rdata_i = mem[bus_adr_o];
            end
         end else begin
            bus_ack_i = 1'b0;
            bus_wait++;
         end
      end else begin
         bus_ack_i = 1'b0;
         bus_wait  = 0;
         hold_v    = 1'b0;
      end
   endtask

   task automatic run_access(input logic we, input logic [21:0] adr, input logic [21:0] wd,
                             input int d0, input int d1, input int d2);
      int exp_stall, n_ok, stall_n;
      bit to, done, posted;
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = 0;
      to = 0; n_ok = 0; exp_stall = 1;
      for (int i = 0; i < 3; i++) begin
         if (dly[i] >= WAIT_MAX) begin
            exp_stall += WAIT_MAX;
            to = 1;
            break;
         end
         exp_stall += dly[i] + 1;
         n_ok++;
         if (i < 2) exp_stall += 1;
      end
      posted = 0;
`ifdef DATA_MEM_BRIDGE_POSTED_WRITE_EN
      posted = we;
`endif
      wr_q.delete();
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_adr_i = adr; cpu_wdata_i = wd;
      stall_n = 0; done = 0;
      if (posted) begin
         bus_step(); #1;
         chk("posted_stall", 32'(cpu_stall_o), 0);
         @(posedge clk_i); #1;
         cpu_req_i = 1'b0;
         for (int c = 1; c < exp_stall; c++) begin
            bus_step(); @(posedge clk_i); #1;
         end
         bus_step(); #1;
         chk("posted_idle", 32'(bus_req_o), 0);
      end else begin
         for (int c = 0; c < 200 && !done; c++) begin
            bus_step(); #1;
            if (cpu_stall_o) begin
               stall_n++;
               @(posedge clk_i); #1;
            end else begin
               done = 1;
            end
         end
         chk("done_reached", 32'(done), 1);
         chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
         chk("req_low_in_done", 32'(bus_req_o), 0);
         if (!we) rd_m = to ? 22'h0 : load_word(adr);
         chk("rdata", 32'(cpu_rdata_o), 32'(rd_m));
         cpu_req_i = 1'b0;
         @(posedge clk_i); #1;
      end
      if (to) err_m = 1'b1;
      chk("bus_err", 32'(bus_err_o), 32'(err_m));
      chk("wr_count", 32'(wr_q.size()), we ? 32'(n_ok) : 0);
      for (int i = 0; i < wr_q.size(); i++) begin
         chk("wr_byte", wr_q[i], {adr, 2'(i), 8'((wd >> (8 * i)) & 22'hFF)});
      end
   endtask

   initial begin
      int stall_n;
      bit done;
      logic [21:0] a, w;
      rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = '0; cpu_wdata_i = '0;
      bus_rdata_i = '0; bus_ack_i = 1'b0; bus_wait = 0; hold_v = 1'b0;
      hold_adr = '0; hold_wd = '0; rd_m = '0; err_m = 1'b0;
      for (int i = 0; i < 4; i++) dly[i] = 0;

      repeat (2) @(posedge clk_i);
      #1 cpu_req_i = 1'b1;
      #1 chk("stall_in_reset", 32'(cpu_stall_o), 0);
      cpu_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_rdata", 32'(cpu_rdata_o), 0);
      chk("rst_req", 32'(bus_req_o), 0);
      chk("rst_we", 32'(bus_we_o), 0);
      chk("rst_adr", 32'(bus_adr_o), 0);
      chk("rst_wdata", 32'(bus_wdata_o), 0);
      chk("rst_err", 32'(bus_err_o), 0);
      chk("rst_stall", 32'(cpu_stall_o), 0);

      run_access(1'b1, 22'h000010, 22'h3ABCDE, 0, 0, 0);
      chk("store_adr_b2", wr_q.size() == 3 ? wr_q[2] : 32'h0, 32'h00004_23A);

      mem[24'h14] = 8'h11; mem[24'h15] = 8'h22; mem[24'h16] = 8'hFF;
      run_access(1'b0, 22'h000005, 22'h0, 0, 0, 0);
      chk("load_3f2211", 32'(cpu_rdata_o), 32'h3F2211);

      run_access(1'b1, 22'h001234, 22'h15A5A5, 3, 3, 3);
      run_access(1'b0, 22'h001234, 22'h0, 3, 3, 3);
      chk("load_after_store", 32'(cpu_rdata_o), 32'h15A5A5);

      for (int n = 0; n < 16; n++) begin
         a = 22'($urandom_range(0, 3)) + 22'h100;
         w = 22'($urandom);
         run_access(1'($urandom), a, w,
                    ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 3)));
      end

      run_access(1'b0, 22'h000200, 22'h0, NEVER, 0, 0);
      chk("timeout_err", 32'(bus_err_o), 1);
      chk("timeout_rdata", 32'(cpu_rdata_o), 0);
      run_access(1'b1, 22'h000201, 22'h2AAAAA, 0, 1, 2);
      chk("err_sticky", 32'(bus_err_o), 1);

      // Reset while byte 1 of a store waits for ack.
      dly[0] = 0; dly[1] = NEVER; dly[2] = 0; dly[3] = 0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 22'h000300; cpu_wdata_i = 22'h123456;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         bus_step(); #1;
         if (bus_req_o && bus_adr_o[1:0] == 2'd1) done = 1;
         else begin @(posedge clk_i); #1; end
      end
      chk("reached_byte1", 32'(done), 1);
      rst_i = 1'b1;
      bus_step(); #1;
      chk("stall_forced_low", 32'(cpu_stall_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; cpu_req_i = 1'b0;
      err_m = 1'b0; rd_m = '0; wr_q.delete();
      bus_step(); #1;
      chk("post_rst_req", 32'(bus_req_o), 0);
      chk("post_rst_stall", 32'(cpu_stall_o), 0);
      chk("post_rst_err", 32'(bus_err_o), 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i); #1; bus_step(); #1;
      end
      chk("no_byte2", 32'(wr_q.size()), 0);
      run_access(1'b1, 22'h000300, 22'h0ABCDE, 0, 0, 0);
      run_access(1'b0, 22'h000300, 22'h0, 1, 0, 2);
      chk("post_rst_load", 32'(cpu_rdata_o), 32'h0ABCDE);

`ifdef DATA_MEM_BRIDGE_POSTED_WRITE_EN
      for (int i = 0; i < 4; i++) dly[i] = 0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 22'h000400; cpu_wdata_i = 22'h31F00D;
      bus_step(); #1;
      chk("posted_store_stall", 32'(cpu_stall_o), 0);
      @(posedge clk_i); #1;
      cpu_we_i = 1'b0; cpu_wdata_i = '0;
      stall_n = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         bus_step(); #1;
         if (cpu_stall_o) begin
            stall_n++;
            @(posedge clk_i); #1;
         end else begin
            done = 1;
         end
      end
      chk("posted_load_done", 32'(done), 1);
      chk("posted_load_stall", 32'(stall_n), 11);
      chk("posted_load_data", 32'(cpu_rdata_o), 32'h31F00D);
      cpu_req_i = 1'b0;
      @(posedge clk_i); #1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
